// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with memory handshake, wait timeout and sticky faults
//
// Sequences one instruction at a time over the shared ALU and memory port.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode                opcode field from the instruction register
//   zero                  ALU zero flag (BEQ decision)
//   mem_ready             memory completes the current access this cycle
//   pc_write, ir_write    PC / instruction+oldPC register enables
//   adr_src               memory address select (0 PC, 1 ALUOut)
//   mem_read, mem_write   memory request strobes
//   reg_write             register file write enable
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU decoder class
//   result_src            result mux select
//   branch                BEQ state active
//   illegal, bus_err      sticky fault flags, cleared only by reset
//   state                 current state code for debug
module multicycle_controller #(
  parameter int OPCODE_W = 7,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                adr_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          result_src,
  output logic                branch,
  output logic                illegal,
  output logic                bus_err,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_LUI      = 4'd10,
    S_JAL      = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ITYPE = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(7'b0110111);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
  localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t              state_q;
  state_t              state_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_state;
  logic                timeout;
  logic                set_illegal;
  logic                set_bus_err;

  assign state = state_q;

  // States that hold on the memory handshake and therefore count wait cycles.
  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  // A ready in the same cycle as the limit is honoured, so the timeout needs !mem_ready.
  assign timeout    = wait_state && !mem_ready && (wait_cnt == WAIT_MAX);

  // State register, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        wait_cnt <= '0;
      end else if (wait_state && !mem_ready) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (set_illegal) begin
        illegal <= 1'b1;
      end
      if (set_bus_err) begin
        bus_err <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_LUI:            state_d = S_LUI;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d     = S_FAULT;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;  // ALUWB then writes the PC+4 computed here
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    if (timeout) begin
      state_d     = S_FAULT;
      set_bus_err = 1'b1;
    end
  end

  // Output logic; pc_write/ir_write in FETCH and pc_write in BEQ are Mealy.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
    // An instruction interrupted by reset must not commit anything.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized and directed bench for multicycle_controller
module tb_multicycle_controller;

  localparam int MAX_WAIT = 255;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, branch;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       illegal, bus_err;
  logic [3:0] state;

  int vectors;
  int miscompares;
  logic [20:0] exp_vec;
  logic [20:0] got_vec;

  // Reference model: current phase, the phases still to run for this
  // instruction, wait cycles spent in the current phase and fault flags.
  int   m_state;
  int   m_wait;
  logic m_ill;
  logic m_bus;
  int   m_todo[$];

  multicycle_controller #(.OPCODE_W(7), .WAIT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .branch(branch),
    .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] model_expect(input logic r, input logic rdy, input logic z);
    logic pcw, irw, adr, mrd, mwr, rw, br;
    logic [1:0] a, b, op, rs;
    logic [3:0] st;
    pcw = 0; irw = 0; adr = 0; mrd = 0; mwr = 0; rw = 0; br = 0;
    a = 0; b = 0; op = 0; rs = 0;
    st = 4'(m_state);
    case (m_state)
      0:  begin mrd = 1; b = 2'b10; rs = 2'b10; pcw = rdy; irw = rdy; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  begin adr = 1; mrd = 1; end
      4:  begin rs = 2'b01; rw = 1; end
      5:  begin adr = 1; mwr = 1; end
      6:  begin a = 2'b10; op = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      8:  begin rw = 1; end
      9:  begin a = 2'b10; op = 2'b01; br = 1; pcw = z; end
      10: begin a = 2'b11; b = 2'b01; op = 2'b11; end
      11: begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: begin end
    endcase
    if (r) begin pcw = 0; irw = 0; rw = 0; mwr = 0; end
    return {pcw, irw, adr, mrd, mwr, rw, a, b, op, rs, br, st, m_ill, m_bus};
  endfunction

  function automatic int next_phase();
    if (m_todo.size() == 0) return 0;
    return m_todo.pop_front();
  endfunction

  function automatic void model_step(input logic r, input logic rdy, input logic [6:0] op);
    int nxt;
    bit known;
    if (r) begin
      m_state = 0; m_wait = 0; m_ill = 0; m_bus = 0; m_todo.delete();
      return;
    end
    nxt = m_state;
    if (m_state == 15) begin
      nxt = 15;
    end else if (m_state == 0 || m_state == 3 || m_state == 5) begin
      if (rdy) nxt = (m_state == 0) ? 1 : next_phase();
      else if (m_wait == MAX_WAIT) begin nxt = 15; m_bus = 1; m_todo.delete(); end
    end else if (m_state == 1) begin
      known = 1;
      m_todo.delete();
      case (op)
        7'b0000011: m_todo = '{2, 3, 4};
        7'b0100011: m_todo = '{2, 5};
        7'b0110011: m_todo = '{6, 8};
        7'b0010011: m_todo = '{7, 8};
        7'b1100011: m_todo = '{9};
        7'b0110111: m_todo = '{10, 8};
        7'b1101111: m_todo = '{11, 8};
        default:    known = 0;
      endcase
      if (known) nxt = next_phase();
      else begin nxt = 15; m_ill = 1; end
    end else begin
      nxt = next_phase();
    end
    if (nxt != m_state) m_wait = 0;
    else if ((m_state == 0 || m_state == 3 || m_state == 5) && !rdy) m_wait++;
    m_state = nxt;
  endfunction

  task automatic sample(input logic r, input logic rdy, input logic z);
    reset = r; mem_ready = rdy; zero = z;
    @(negedge clk);
    exp_vec = model_expect(r, rdy, z);
    got_vec = {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, alu_src_a,
               alu_src_b, alu_op, result_src, branch, state, illegal, bus_err};
  endtask

  task automatic advance();
    model_step(reset, mem_ready, opcode);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; mem_ready = 1; zero = 0; opcode = 7'b0110011;
    @(posedge clk);
    #1;
    model_step(1'b1, 1'b1, opcode);
    sample(1'b1, 1'b1, 1'b0);
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
    vectors++;
    if ({illegal, bus_err} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b want 00", {illegal, bus_err}); end
    vectors++;
    if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 0000", {pc_write, ir_write, reg_write, mem_write});
    end
    vectors++;
    if (got_vec !== exp_vec) begin miscompares++; $display("FAIL reset_model: got %h want %h", got_vec, exp_vec); end
    advance();
  endtask

  task automatic test_add();
    logic [3:0] st[5];
    logic rw[5];
    logic pcw[5];
    int exp_st[5] = '{0, 1, 6, 8, 0};
    opcode = 7'b0110011;
    sample(1'b1, 1'b1, 1'b0);
    vectors++;
    if (got_vec !== exp_vec) begin miscompares++; $display("FAIL add_reset: got %h want %h", got_vec, exp_vec); end
    advance();
    for (int i = 0; i < 5; i++) begin
      sample(1'b0, 1'b1, 1'b0);
      st[i] = state; rw[i] = reg_write; pcw[i] = pc_write;
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL add_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (st[i] !== 4'(exp_st[i])) begin miscompares++; $display("FAIL add_state cyc %0d: got %0d want %0d", i, st[i], exp_st[i]); end
      vectors++;
      if (rw[i] !== (i == 3)) begin miscompares++; $display("FAIL add_reg_write cyc %0d: got %b want %b", i, rw[i], i == 3); end
      if (i < 4) begin
        vectors++;
        if (pcw[i] !== (i == 0)) begin miscompares++; $display("FAIL add_pc_write cyc %0d: got %b want %b", i, pcw[i], i == 0); end
      end
    end
  endtask

  task automatic test_lw_wait();
    int lows = 0;
    int rd_cycles = 0;
    bit seen_wb = 0;
    bit done = 0;
    logic rdy;
    opcode = 7'b0000011;
    sample(1'b1, 1'b1, 1'b0);
    vectors++;
    if (got_vec !== exp_vec) begin miscompares++; $display("FAIL lw_reset: got %h want %h", got_vec, exp_vec); end
    advance();
    for (int i = 0; i < 30 && !done; i++) begin
      rdy = 1'b1;
      if (m_state == 3 && lows < 3) begin rdy = 1'b0; lows++; end
      sample(1'b0, rdy, 1'b0);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL lw_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      if (state == 4'd3 && mem_read) rd_cycles++;
      if (state == 4'd4) begin
        seen_wb = 1;
        vectors++;
        if (result_src !== 2'b01) begin miscompares++; $display("FAIL lw_result_src: got %b want 01", result_src); end
      end
      if (seen_wb && state == 4'd0) done = 1;
      advance();
    end
    vectors++;
    if (rd_cycles !== 4) begin miscompares++; $display("FAIL lw_memread_cycles: got %0d want 4", rd_cycles); end
    vectors++;
    if (seen_wb !== 1'b1) begin miscompares++; $display("FAIL lw_memwb_reached: got %b want 1", seen_wb); end
    vectors++;
    if (bus_err !== 1'b0) begin miscompares++; $display("FAIL lw_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_beq();
    int n_beq = 0;
    logic pcw[2];
    logic br[2];
    logic z;
    opcode = 7'b1100011;
    sample(1'b1, 1'b1, 1'b0);
    vectors++;
    if (got_vec !== exp_vec) begin miscompares++; $display("FAIL beq_reset: got %h want %h", got_vec, exp_vec); end
    advance();
    for (int i = 0; i < 6; i++) begin
      z = (i < 3);
      sample(1'b0, 1'b1, z);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL beq_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      if (state == 4'd9 && n_beq < 2) begin pcw[n_beq] = pc_write; br[n_beq] = branch; n_beq++; end
      advance();
    end
    vectors++;
    if (n_beq !== 2) begin miscompares++; $display("FAIL beq_count: got %0d want 2", n_beq); end
    else begin
      vectors++;
      if ({pcw[0], pcw[1]} !== 2'b10) begin miscompares++; $display("FAIL beq_pc_write: got %b want 10", {pcw[0], pcw[1]}); end
      vectors++;
      if ({br[0], br[1]} !== 2'b11) begin miscompares++; $display("FAIL beq_branch: got %b want 11", {br[0], br[1]}); end
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111;
    sample(1'b1, 1'b1, 1'b0);
    vectors++;
    if (got_vec !== exp_vec) begin miscompares++; $display("FAIL ill_reset: got %h want %h", got_vec, exp_vec); end
    advance();
    for (int i = 0; i < 12; i++) begin
      sample(1'b0, 1'b1, 1'b1);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL ill_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      if (i == 1) begin
        vectors++;
        if (state !== 4'd1) begin miscompares++; $display("FAIL ill_decode: got %0d want 1", state); end
      end
      if (i >= 2) begin
        vectors++;
        if ({state, illegal} !== 5'b11111) begin miscompares++; $display("FAIL ill_fault cyc %0d: got %b want 11111", i, {state, illegal}); end
        vectors++;
        if ({pc_write, ir_write, mem_read, mem_write, reg_write, branch} !== 6'b0) begin
          miscompares++; $display("FAIL ill_strobes cyc %0d: got %b want 000000", i,
                                  {pc_write, ir_write, mem_read, mem_write, reg_write, branch});
        end
      end
      advance();
    end
    sample(1'b1, 1'b0, 1'b0);
    advance();
    sample(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({state, illegal} !== 5'b00000) begin miscompares++; $display("FAIL ill_cleared: got %b want 00000", {state, illegal}); end
    advance();
  endtask

  task automatic test_timeout();
    bit all_fetch = 1;
    opcode = 7'b0110011;
    sample(1'b1, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 256; i++) begin
      sample(1'b0, 1'b0, 1'b0);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL tmo_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      if (state != 4'd0) all_fetch = 0;
      advance();
    end
    sample(1'b0, 1'b0, 1'b0);
    vectors++;
    if (all_fetch !== 1'b1) begin miscompares++; $display("FAIL tmo_held_fetch: got %b want 1", all_fetch); end
    vectors++;
    if ({state, bus_err} !== 5'b11111) begin miscompares++; $display("FAIL tmo_fault: got %b want 11111", {state, bus_err}); end
    advance();
    sample(1'b1, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 256; i++) begin
      sample(1'b0, (i == 255), 1'b0);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL tmo2_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      advance();
    end
    sample(1'b0, 1'b1, 1'b0);
    vectors++;
    if ({state, bus_err} !== 5'b00010) begin miscompares++; $display("FAIL tmo_late_ready: got %b want 00010", {state, bus_err}); end
    advance();
  endtask

  task automatic test_reset_memwrite();
    opcode = 7'b0100011;
    sample(1'b1, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 1'b1, 1'b0);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL sw_model cyc %0d: got %h want %h", i, got_vec, exp_vec); end
      advance();
    end
    sample(1'b1, 1'b1, 1'b0);
    vectors++;
    if ({state, mem_write} !== 5'b01010) begin miscompares++; $display("FAIL sw_reset_memwrite: got %b want 01010", {state, mem_write}); end
    advance();
    sample(1'b0, 1'b0, 1'b0);
    vectors++;
    if (state !== 4'd0) begin miscompares++; $display("FAIL sw_after_reset: got %0d want 0", state); end
    advance();
  endtask

  task automatic test_random();
    logic [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b0110111, 7'b1101111};
    logic r, rdy, z;
    sample(1'b1, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 0) begin
        if ($urandom_range(0, 15) == 0) opcode = 7'($urandom);
        else opcode = ops[$urandom_range(0, 6)];
      end
      r   = (m_state == 15) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      z   = 1'($urandom);
      sample(r, rdy, z);
      vectors++;
      if (got_vec !== exp_vec) begin miscompares++; $display("FAIL rand_model cyc %0d op %b: got %h want %h", i, opcode, got_vec, exp_vec); end
      advance();
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_state = 0; m_wait = 0; m_ill = 0; m_bus = 0;
    reset = 1; mem_ready = 0; zero = 0; opcode = 7'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_memwrite();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
